// File: rtl/rle_ctrl.sv
// rle_ctrl: capture controller sitting between a sample front end, an RLE
// encoder and a capture FIFO. Runs a capture from start until stop or a
// sample limit, routing either raw samples (bypass) or encoder words (RLE)
// into the FIFO, and drains the encoder for three cycles before finishing.
module rle_ctrl (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_rle_en,
    input  logic [31:0] cfg_sample_limit,
    input  logic [15:0] cap_data,
    input  logic        cap_valid,
    input  logic [15:0] rle_data,
    input  logic        rle_valid,
    output logic        enc_clr,
    output logic        enc_in_valid,
    output logic        enc_flush,
    output logic [15:0] fifo_wdata,
    output logic        fifo_wen,
    input  logic        fifo_full,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [31:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rle_en;
    logic [31:0] r_limit;
    logic [31:0] r_sample_cnt;
    logic [1:0]  r_flush_cnt;
    logic        r_enc_clr;
    logic        r_enc_flush;
    logic        r_fifo_wen;
    logic [15:0] r_fifo_wdata;
    logic        r_overflow;

    logic        w_accept_start;
    logic        w_sample;
    logic [31:0] w_cnt_inc;
    logic        w_limit_hit;
    logic        w_run_end;
    logic        w_flush_last;
    logic        w_wr_req;
    logic [15:0] w_wr_data;

    // Decode of capture events shared by the FSM and the datapath
    always_comb begin
        w_accept_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
        w_sample       = (r_state == S_RUN) && cap_valid;
        w_cnt_inc      = (r_sample_cnt == '1) ? r_sample_cnt : (r_sample_cnt + 32'd1);
        w_limit_hit    = w_sample && (r_limit != '0) && (w_cnt_inc == r_limit);
        w_run_end      = (r_state == S_RUN) && (stop || w_limit_hit);
        w_flush_last   = (r_state == S_FLUSH) && (r_flush_cnt == 2'd2);
        w_wr_req       = 1'b0;
        w_wr_data      = '0;
        if (r_rle_en) begin
            w_wr_req  = ((r_state == S_RUN) || (r_state == S_FLUSH)) && rle_valid;
            w_wr_data = rle_data;
        end else begin
            w_wr_req  = w_sample;
            w_wr_data = cap_data;
        end
    end

    // FSM state register
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_state_nxt  = r_state;
        enc_in_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy         = 1'b1;
                enc_in_valid = r_rle_en && cap_valid;
                if (w_run_end) w_state_nxt = r_rle_en ? S_FLUSH : S_DONE;
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (w_flush_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (w_accept_start) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture config latch, sample counter and flush timer
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_rle_en     <= 1'b0;
            r_limit      <= '0;
            r_sample_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_accept_start) begin
                r_rle_en     <= cfg_rle_en;
                r_limit      <= cfg_sample_limit;
                r_sample_cnt <= '0;
            end else if (w_sample) begin
                r_sample_cnt <= w_cnt_inc;
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    // Registered encoder strobes, FIFO write path and sticky overflow
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_enc_clr    <= 1'b0;
            r_enc_flush  <= 1'b0;
            r_fifo_wen   <= 1'b0;
            r_fifo_wdata <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_enc_clr   <= w_accept_start;
            r_enc_flush <= w_run_end && r_rle_en;
            // fifo_full is judged when the write is committed; a dropped
            // word only marks overflow and never holds up the capture.
            r_fifo_wen  <= w_wr_req && !fifo_full;
            if (w_wr_req && !fifo_full) begin
                r_fifo_wdata <= w_wr_data;
            end
            if (w_accept_start) begin
                r_overflow <= 1'b0;
            end else if (w_wr_req && fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign enc_clr    = r_enc_clr;
    assign enc_flush  = r_enc_flush;
    assign fifo_wen   = r_fifo_wen;
    assign fifo_wdata = r_fifo_wdata;
    assign overflow   = r_overflow;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_rle_ctrl.sv
// tb_rle_ctrl: directed scenarios followed by a randomized run, every cycle
// compared against a behavioural model of the capture rules.
module tb_rle_ctrl;

    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, cfg_rle_en = 1'b0;
    logic [31:0] cfg_sample_limit = '0;
    logic [15:0] cap_data = '0, rle_data = '0;
    logic        cap_valid = 1'b0, rle_valid = 1'b0, fifo_full = 1'b0;
    logic        enc_clr, enc_in_valid, enc_flush, fifo_wen, busy, done, overflow;
    logic [15:0] fifo_wdata;
    logic [31:0] sample_cnt;

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int n_flush = 0;

    // behavioural model
    bit          m_run, m_done, m_rle, m_ovf;
    int          m_flush_left;
    longint      m_cnt, m_limit;
    bit          e_clr, e_flush, e_wen;
    logic [15:0] e_wdata;

    rle_ctrl dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n), .start(start), .stop(stop),
        .cfg_rle_en(cfg_rle_en), .cfg_sample_limit(cfg_sample_limit),
        .cap_data(cap_data), .cap_valid(cap_valid), .rle_data(rle_data),
        .rle_valid(rle_valid), .enc_clr(enc_clr), .enc_in_valid(enc_in_valid),
        .enc_flush(enc_flush), .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen),
        .fifo_full(fifo_full), .busy(busy), .done(done), .overflow(overflow),
        .sample_cnt(sample_cnt)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_rle = 0; m_ovf = 0; m_flush_left = 0;
        m_cnt = 0; m_limit = 0; e_clr = 0; e_flush = 0; e_wen = 0; e_wdata = '0;
    endtask

    task automatic model_write(input logic [15:0] d, input bit full);
        if (full) m_ovf = 1;
        else begin
            e_wen = 1;
            e_wdata = d;
        end
    endtask

    task automatic chk_outs();
        chk("busy", {31'd0, busy}, {31'd0, (m_run || m_flush_left > 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("sample_cnt", sample_cnt, m_cnt[31:0]);
        chk("enc_clr", {31'd0, enc_clr}, {31'd0, e_clr});
        chk("enc_flush", {31'd0, enc_flush}, {31'd0, e_flush});
        chk("fifo_wen", {31'd0, fifo_wen}, {31'd0, e_wen});
        if (e_wen) chk("fifo_wdata", {16'd0, fifo_wdata}, {16'd0, e_wdata});
    endtask

    // one clock cycle with the given inputs held across the rising edge
    task automatic step(input logic st, input logic sp, input logic cv,
                        input logic [15:0] cd, input logic rv,
                        input logic [15:0] rd, input logic ff);
        bit ended;
        start = st; stop = sp; cap_valid = cv; cap_data = cd;
        rle_valid = rv; rle_data = rd; fifo_full = ff;
        #1;
        chk("enc_in_valid", {31'd0, enc_in_valid}, {31'd0, (m_run && m_rle && cv)});
        e_clr = 0; e_flush = 0; e_wen = 0;
        if (m_run) begin
            if (cv) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (!m_rle) model_write(cd, ff);
            end
            if (rv && m_rle) model_write(rd, ff);
            ended = sp || (cv && m_limit != 0 && m_cnt == m_limit);
            if (ended) begin
                m_run = 0;
                if (m_rle) begin
                    m_flush_left = 3;
                    e_flush = 1;
                end else m_done = 1;
            end
        end else if (m_flush_left > 0) begin
            if (rv) model_write(rd, ff);
            m_flush_left--;
            if (m_flush_left == 0) m_done = 1;
        end else if (st) begin
            m_run = 1; m_done = 0; m_ovf = 0; m_cnt = 0;
            m_rle = cfg_rle_en; m_limit = longint'(cfg_sample_limit);
            e_clr = 1;
        end
        @(posedge core_clk);
        #1;
        chk_outs();
        if (fifo_wen) n_wr++;
        if (enc_flush) n_flush++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 16'h0, 0);
    endtask

    // asynchronous reset asserted between clock edges
    task automatic do_reset();
        core_rst_n = 0;
        #1;
        model_reset();
        chk("rst_enc_in_valid", {31'd0, enc_in_valid}, 32'd0);
        chk_outs();
        #2;
        core_rst_n = 1;
    endtask

    initial begin
        model_reset();
        #1;
        chk_outs();
        @(posedge core_clk); #1;
        @(posedge core_clk); #1;
        core_rst_n = 1;
        idle(1);

        // bypass, limit 4, six samples
        cfg_rle_en = 0; cfg_sample_limit = 32'd4;
        n_wr = 0;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        for (int i = 1; i <= 6; i++) step(0, 0, 1, 16'(i), 0, 16'h0, 0);
        idle(2);
        chk("bypass_writes", n_wr, 32'd4);
        chk("bypass_cnt", sample_cnt, 32'd4);

        // RLE, unlimited, ten samples then stop
        cfg_rle_en = 1; cfg_sample_limit = 32'd0;
        n_wr = 0; n_flush = 0;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 16'h1111, i[0], 16'hA000 + 16'(i), 0);
        step(0, 1, 0, 16'h0, 1, 16'hB000, 0);
        step(0, 0, 0, 16'h0, 1, 16'hB001, 0);
        step(0, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 1, 16'hB002, 0);
        idle(2);
        chk("rle_writes", n_wr, 32'd8);
        chk("rle_flush_pulses", n_flush, 32'd1);

        // bypass, full held around the 2nd of 3 writes
        cfg_rle_en = 0; cfg_sample_limit = 32'd0;
        n_wr = 0;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h0011, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h0022, 0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 0, 16'h0, 1);
        step(0, 0, 1, 16'h0033, 0, 16'h0, 0);
        step(0, 1, 0, 16'h0, 0, 16'h0, 0);
        idle(3);
        chk("full_writes", n_wr, 32'd2);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        cfg_rle_en = 1;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        step(0, 1, 0, 16'h0, 0, 16'h0, 0);
        idle(4);

        // stop together with the limit-reaching sample
        cfg_rle_en = 1; cfg_sample_limit = 32'd3;
        n_flush = 0;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h1, 0, 16'h0, 0);
        step(0, 0, 1, 16'h2, 0, 16'h0, 0);
        step(0, 1, 1, 16'h3, 0, 16'h0, 0);
        idle(5);
        chk("coinc_cnt", sample_cnt, 32'd3);
        chk("coinc_flush_pulses", n_flush, 32'd1);

        // reset during FLUSH, then a normal capture
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h5, 1, 16'h55, 0);
        step(0, 1, 0, 16'h0, 1, 16'h66, 0);
        step(0, 0, 0, 16'h0, 1, 16'h77, 0);
        do_reset();
        cfg_rle_en = 0; cfg_sample_limit = 32'd2;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 1, 16'hC1, 0, 16'h0, 0);
        step(0, 0, 1, 16'hC2, 0, 16'h0, 0);
        idle(2);

        // start and mode toggle during RUN are ignored
        cfg_rle_en = 0; cfg_sample_limit = 32'd0;
        step(1, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 1, 16'hD1, 1, 16'hE1, 0);
        cfg_rle_en = 1;
        step(1, 0, 1, 16'hD2, 1, 16'hE2, 0);
        step(0, 0, 1, 16'hD3, 1, 16'hE3, 0);
        chk("midrun_cnt", sample_cnt, 32'd3);
        step(0, 1, 0, 16'h0, 0, 16'h0, 0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) cfg_rle_en = 1'($urandom);
            if ($urandom_range(0, 9) == 0) cfg_sample_limit = $urandom_range(0, 8);
            if ($urandom_range(0, 399) == 0) do_reset();
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 0), 16'($urandom),
                 ($urandom_range(0, 2) == 0), 16'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rle_ctrl.md
RLE_CTRL -- requirements
Module: rle_ctrl

Interface
REQ-001 Port core_clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 Port core_rst_n, input, 1: asynchronous, active-low reset.
REQ-003 Port start, input, 1: capture start request, single-cycle pulse.
REQ-004 Port stop, input, 1: capture stop request, single-cycle pulse.
REQ-005 Port cfg_rle_en, input, 1: 1 = RLE mode, 0 = raw bypass mode.
REQ-006 Port cfg_sample_limit, input, 32: samples per capture; 0 = unlimited.
REQ-007 Port cap_data, input, 16: raw sample from the capture front end.
REQ-008 Port cap_valid, input, 1: cap_data qualifier.
REQ-009 Port rle_data, input, 16: encoded word returned by the encoder.
REQ-010 Port rle_valid, input, 1: rle_data qualifier.
REQ-011 Port enc_clr, output, 1: clears the encoder's run state.
REQ-012 Port enc_in_valid, output, 1: sample strobe to the encoder.
REQ-013 Port enc_flush, output, 1: forces the encoder to emit its pending run.
REQ-014 Port fifo_wdata, output, 16: data word to the capture FIFO.
REQ-015 Port fifo_wen, output, 1: FIFO write strobe.
REQ-016 Port fifo_full, input, 1: FIFO cannot accept a write this cycle.
REQ-017 Port busy, output, 1: capture in progress (RUN or FLUSH).
REQ-018 Port done, output, 1: capture finished; sticky until next start.
REQ-019 Port overflow, output, 1: sticky; at least one word dropped.
REQ-020 Port sample_cnt, output, 32: number of samples accepted in the current capture.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, FLUSH, DONE.
REQ-022 IDLE/DONE + start SHALL: go to RUN; pulse enc_clr for exactly 1 cycle; clear sample_cnt, overflow, done; latch cfg_rle_en and cfg_sample_limit.
REQ-023 Latched config SHALL stay fixed until the next start; config changes mid-capture are ignored.
REQ-024 In RUN, each cycle with cap_valid=1 SHALL increment sample_cnt by 1.
REQ-025 In RUN, enc_in_valid SHALL equal cap_valid when RLE mode is latched, else 0.
REQ-026 sample_cnt SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-027 RUN SHALL end on stop=1, or on a cap_valid sample that makes sample_cnt equal a nonzero limit; that sample is counted and forwarded.
REQ-028 stop and limit-reach in the same cycle SHALL cause a single transition.
REQ-029 Transition targets: RLE mode -> FLUSH, with enc_flush=1 for the first FLUSH cycle only; bypass mode -> DONE directly.
REQ-030 FLUSH SHALL last exactly 3 cycles and then go to DONE.
REQ-031 rle_valid words arriving in FLUSH SHALL still be written to the FIFO.
REQ-032 Bypass mode SHALL write fifo_wdata=cap_data with fifo_wen=1 exactly 1 cycle after each accepted cap_valid, both registered.
REQ-033 RLE mode SHALL write fifo_wdata=rle_data with fifo_wen=1 exactly 1 cycle after each rle_valid seen in RUN or FLUSH.
REQ-034 Inputs SHALL be ignored in IDLE/DONE: cap_valid and rle_valid cause no write and no count; stop causes no action.
REQ-035 start SHALL be ignored in RUN and FLUSH.
REQ-036 If fifo_full=1 in the cycle a write would issue, fifo_wen SHALL stay 0, the word SHALL be dropped, and overflow SHALL set.
REQ-037 A drop SHALL NOT stall the FSM or the sample count.
REQ-038 busy SHALL be 1 exactly in RUN and FLUSH.
REQ-039 done SHALL be 1 from DONE entry until the next accepted start.

Reset
REQ-040 core_rst_n=0 SHALL immediately force state IDLE, and all outputs and sample_cnt to 0, including mid-capture; pending words are discarded.
REQ-041 After core_rst_n deasserts, the block SHALL respond to the first start pulse on any following rising edge.

Verification
REQ-042 Bypass mode, limit=4, start, then 6 cap_valid words 0x0001..0x0006 -> 4 FIFO writes 0x0001..0x0004, each 1 cycle late; done=1; sample_cnt=4; no FLUSH state.
REQ-043 RLE mode, limit=0, start, 10 samples, stop -> enc_clr 1 cycle after start; enc_flush 1 cycle after stop; DONE 3 cycles later; every rle_valid word written.
REQ-044 fifo_full=1 during the 2nd of 3 bypass writes -> 2 writes issued; overflow=1 and stays 1 until the next start clears it.
REQ-045 stop coincident with the limit-reaching sample (limit=3) -> sample_cnt=3; one FLUSH entry; enc_flush a single pulse.
REQ-046 core_rst_n low during FLUSH -> all outputs 0 at once; state IDLE; next start runs a normal capture.
REQ-047 start pulse during RUN, and cfg_rle_en toggled during RUN -> no effect; sample_cnt continuous; mode unchanged.
